// File: rtl/i2c_fifo.sv
// -----------------------------------------------------------------------------
// i2c_fifo
//   Synchronous first-word-fall-through FIFO used twice beside the APB bridge:
//   as the TX FIFO (bridge writes, I2C core reads) and as the RX FIFO (I2C core
//   writes, bridge reads). The head word is presented on DATA_OUT with zero
//   read latency so the bridge can return it combinationally on PRDATA.
//
// Ports
//   PCLK         in   clock, all state on rising edge
//   PRESETn      in   asynchronous active-low reset
//   CLR          in   synchronous flush, wins over WR_EN/RD_EN
//   WR_EN        in   push DATA_IN this edge
//   DATA_IN      in   write data [DWIDTH-1:0]
//   RD_EN        in   pop head entry this edge
//   DATA_OUT     out  head entry, valid while EMPTY=0 [DWIDTH-1:0]
//   FULL         out  COUNT == DEPTH
//   EMPTY        out  COUNT == 0
//   ALMOST_FULL  out  COUNT >= AF_LEVEL
//   ALMOST_EMPTY out  COUNT <= AE_LEVEL
//   COUNT        out  occupancy 0..DEPTH [AW:0]
//   OVERFLOW     out  one-cycle pulse on a rejected write
//   UNDERFLOW    out  one-cycle pulse on a rejected read
//   ERROR        out  sticky OR of OVERFLOW/UNDERFLOW, cleared by CLR or reset
// -----------------------------------------------------------------------------
module i2c_fifo #(
  parameter  int DWIDTH   = 32,
  parameter  int DEPTH    = 16,
  parameter  int AF_LEVEL = DEPTH - 2,
  parameter  int AE_LEVEL = 2,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              CLR,
  input  logic              WR_EN,
  input  logic [DWIDTH-1:0] DATA_IN,
  input  logic              RD_EN,
  output logic [DWIDTH-1:0] DATA_OUT,
  output logic              FULL,
  output logic              EMPTY,
  output logic              ALMOST_FULL,
  output logic              ALMOST_EMPTY,
  output logic [AW:0]       COUNT,
  output logic              OVERFLOW,
  output logic              UNDERFLOW,
  output logic              ERROR
);

  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT    = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] AE_CNT    = (AW + 1)'(AE_LEVEL);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              afull_q, afull_d;
  logic              aempty_q, aempty_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              err_q, err_d;

  logic              wr_acc;
  logic              rd_acc;

  // Full implies non-empty, so a simultaneous read always frees the slot the
  // write needs; the FIFO never rejects a write paired with a valid read.
  assign wr_acc = !CLR && WR_EN && (!full_q || (RD_EN && !empty_q));
  assign rd_acc = !CLR && RD_EN && !empty_q;

  // NOTE: every signal assigned in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    err_d    = err_q;

    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;

      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase

      ovf_d = WR_EN && !wr_acc;
      unf_d = RD_EN && empty_q;
      err_d = err_q || ovf_d || unf_d;

      // Register the next head word. When the new read pointer lands on the
      // slot being written this edge, the storage does not hold it yet, so the
      // incoming word is forwarded. With nothing left, the last value is held.
      if (count_d != '0) begin
        if (wr_acc && (rd_ptr_d == wr_ptr_q)) dout_d = DATA_IN;
        else                                  dout_d = mem_q[rd_ptr_d];
      end
    end

    // Flags are derived from the next occupancy so they move with COUNT.
    full_d   = (count_d == DEPTH_CNT);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_CNT);
    aempty_d = (count_d <= AE_CNT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      err_q    <= err_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the pointers and COUNT
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge PCLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= DATA_IN;
  end

  assign DATA_OUT     = dout_q;
  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
  assign COUNT        = count_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;
  assign ERROR        = err_q;

endmodule

// File: tb/tb_i2c_fifo.sv
// -----------------------------------------------------------------------------
// tb_i2c_fifo
//   Directed bench for i2c_fifo (DWIDTH=32, DEPTH=16). A queue holds the words
//   the FIFO should contain; writes push expected data, reads pop and compare
//   against DATA_OUT in the cycle RD_EN is asserted. Flags are predicted from
//   the queue size after every edge.
// -----------------------------------------------------------------------------
module tb_i2c_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          PCLK;
  logic          PRESETn;
  logic          CLR;
  logic          WR_EN;
  logic [DW-1:0] DATA_IN;
  logic          RD_EN;
  logic [DW-1:0] DATA_OUT;
  logic          FULL;
  logic          EMPTY;
  logic          ALMOST_FULL;
  logic          ALMOST_EMPTY;
  logic [AW:0]   COUNT;
  logic          OVERFLOW;
  logic          UNDERFLOW;
  logic          ERROR;

  i2c_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .PCLK        (PCLK),
    .PRESETn     (PRESETn),
    .CLR         (CLR),
    .WR_EN       (WR_EN),
    .DATA_IN     (DATA_IN),
    .RD_EN       (RD_EN),
    .DATA_OUT    (DATA_OUT),
    .FULL        (FULL),
    .EMPTY       (EMPTY),
    .ALMOST_FULL (ALMOST_FULL),
    .ALMOST_EMPTY(ALMOST_EMPTY),
    .COUNT       (COUNT),
    .OVERFLOW    (OVERFLOW),
    .UNDERFLOW   (UNDERFLOW),
    .ERROR       (ERROR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Scoreboard and reference state
  logic [DW-1:0] sb_q[$];
  logic          m_err;
  logic          m_ovf;
  logic          m_unf;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output against the reference after an edge or reset.
  task automatic check_all(input string tag);
    int n;
    n = sb_q.size();
    check({tag, " COUNT"},        DW'(COUNT),        DW'(n));
    check({tag, " EMPTY"},        DW'(EMPTY),        DW'(n == 0));
    check({tag, " FULL"},         DW'(FULL),         DW'(n == DEPTH));
    check({tag, " ALMOST_FULL"},  DW'(ALMOST_FULL),  DW'(n >= DEPTH - 2));
    check({tag, " ALMOST_EMPTY"}, DW'(ALMOST_EMPTY), DW'(n <= 2));
    check({tag, " OVERFLOW"},     DW'(OVERFLOW),     DW'(m_ovf));
    check({tag, " UNDERFLOW"},    DW'(UNDERFLOW),    DW'(m_unf));
    check({tag, " ERROR"},        DW'(ERROR),        DW'(m_err));
    if (n != 0) check({tag, " HEAD"}, DATA_OUT, sb_q[0]);
  endtask

  // One clock of stimulus; inputs are driven 1 time unit after an edge.
  task automatic step(input string tag, input logic wr, input logic [DW-1:0] din,
                      input logic rd, input logic clr = 1'b0);
    bit full_now, empty_now;
    full_now  = (sb_q.size() == DEPTH);
    empty_now = (sb_q.size() == 0);
    WR_EN   = wr;
    DATA_IN = din;
    RD_EN   = rd;
    CLR     = clr;
    if (clr) begin
      sb_q.delete();
      m_err = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      m_ovf = wr && full_now && !rd;
      m_unf = rd && empty_now;
      if (rd && !empty_now) begin
        // The bridge samples the head in the same cycle it asserts RD_EN.
        check({tag, " RDATA"}, DATA_OUT, sb_q[0]);
        void'(sb_q.pop_front());
      end
      if (wr && !m_ovf) sb_q.push_back(din);
      m_err = m_err || m_ovf || m_unf;
    end
    @(posedge PCLK);
    #1;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    CLR   = 1'b0;
    check_all(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    PRESETn = 1'b0;
    CLR     = 1'b0;
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    DATA_IN = '0;

    // Reset then idle
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    check_all("reset");
    check("reset DATA_OUT", DATA_OUT, '0);
    step("idle", 1'b0, '0, 1'b0);

    // Fill with 16 words then drain in order
    for (int i = 1; i <= DEPTH; i++) step("fill", 1'b1, 32'hA5A5_0000 + DW'(i), 1'b0);
    for (int i = 0; i < DEPTH; i++)  step("drain", 1'b0, '0, 1'b1);

    // Overflow on a full FIFO
    for (int i = 1; i <= DEPTH; i++) step("refill", 1'b1, 32'hB000_0000 + DW'(i), 1'b0);
    step("overflow", 1'b1, 32'hDEAD_BEEF, 1'b0);
    step("ovf_gone", 1'b0, '0, 1'b0);

    // Simultaneous read/write at full: both accepted
    step("full_rw", 1'b1, 32'h1234_5678, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) check("last_is_new", sb_q[0], 32'h1234_5678);
      step("drain2", 1'b0, '0, 1'b1);
    end

    // Read plus write on empty: read rejected, write accepted
    step("empty_rw", 1'b1, 32'h0000_CAFE, 1'b1);
    step("empty_rw_idle", 1'b0, '0, 1'b0);
    step("empty_rw_pop", 1'b0, '0, 1'b1);

    // Write 20 / read 18 interleaved across the pointer wrap
    for (int i = 0; i < 20; i++)
      step("wrap", 1'b1, 32'hC000_0000 + DW'(i * 7 + 3), (i >= 2));

    // Flush with COUNT=5 and ERROR=1; the concurrent write is ignored
    for (int i = 0; i < 3; i++) step("pre_clr", 1'b1, 32'hD000_0000 + DW'(i), 1'b0);
    check("pre_clr COUNT", DW'(COUNT), 32'd5);
    check("pre_clr ERROR", DW'(ERROR), 32'd1);
    step("clr", 1'b1, 32'hEEEE_EEEE, 1'b1, 1'b1);

    // Asynchronous reset mid-cycle with COUNT=7
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, 32'hF000_0000 + DW'(i), 1'b0);
    step("pre_rst_ovf", 1'b0, '0, 1'b1);
    for (int i = 0; i < 1; i++) step("pre_rst_top", 1'b1, 32'hF000_00FF, 1'b0);
    #2 PRESETn = 1'b0;
    sb_q.delete();
    m_err = 1'b0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    #1;
    check_all("async_rst");
    check("async_rst DATA_OUT", DATA_OUT, '0);
    #2 PRESETn = 1'b1;
    @(posedge PCLK);
    #1;
    check_all("post_rst");
    step("post_rst_wr", 1'b1, 32'h0BAD_F00D, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_fifo.md
Name: i2c_fifo

Overview:
- Synchronous first-word-fall-through FIFO; instantiated twice beside the APB bridge: TX FIFO (bridge writes, I2C core reads) and RX FIFO (I2C core writes, bridge reads).
- Produces the empty flags consumed by the bridge as TX_EMPTY/RX_EMPTY interrupts, and the head word the bridge returns combinationally on PRDATA.
- Flags overflow and underflow so the core can raise ERROR.

Parameters:
- DWIDTH, 32, data word width.
- DEPTH, 16, number of entries; power of two, minimum 2.
- AW, log2(DEPTH), pointer width; derived, not overridden.
- AF_LEVEL, DEPTH-2, ALMOST_FULL asserts when COUNT >= AF_LEVEL.
- AE_LEVEL, 2, ALMOST_EMPTY asserts when COUNT <= AE_LEVEL.

Ports:
- PCLK  in  1  clock, all state on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- CLR  in  1  synchronous flush, priority over WR_EN/RD_EN.
- WR_EN  in  1  push DATA_IN this edge.
- DATA_IN  in  DWIDTH  write data.
- RD_EN  in  1  pop head entry this edge.
- DATA_OUT  out  DWIDTH  head entry, valid combinationally while EMPTY=0.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- ALMOST_FULL  out  1  COUNT >= AF_LEVEL.
- ALMOST_EMPTY  out  1  COUNT <= AE_LEVEL.
- COUNT  out  AW+1  current occupancy, 0..DEPTH.
- OVERFLOW  out  1  one-cycle pulse: rejected write.
- UNDERFLOW  out  1  one-cycle pulse: rejected read.
- ERROR  out  1  sticky OR of overflow and underflow; cleared only by CLR or reset.

Behaviour:
- Reset (PRESETn low, asynchronous): read/write pointers = 0, COUNT = 0, EMPTY = 1, ALMOST_EMPTY = 1, FULL = 0, ALMOST_FULL = 0, OVERFLOW = UNDERFLOW = ERROR = 0, DATA_OUT = 0. Storage contents are not reset. Release takes effect on the first rising PCLK after deassertion.
- Storage: DEPTH x DWIDTH register array. Write pointer and read pointer are AW bits and wrap DEPTH-1 -> 0. COUNT is a separate AW+1 bit register.
- Write accepted when WR_EN=1 and (FULL=0, or RD_EN=1 with EMPTY=0). DATA_IN is stored at the write pointer, and the write pointer increments.
- Read accepted when RD_EN=1 and EMPTY=0. The read pointer increments. DATA_OUT shows the next entry after the edge, with zero-cycle read latency (first-word fall-through). The bridge samples DATA_OUT in the same cycle it asserts RD_EN.
- COUNT update: +1 on write only, -1 on read only, unchanged on both or neither.
- Write latency: a word written at edge N is visible on DATA_OUT after edge N if the FIFO was empty. EMPTY deasserts after edge N.
- All flags are registered, derived from the next COUNT, and change on the same edge as COUNT.
- Full + WR_EN + RD_EN: both accepted, COUNT stays DEPTH, no OVERFLOW.
- Full + WR_EN only: write dropped, pointers unchanged, OVERFLOW pulses 1 cycle, ERROR set.
- Empty + RD_EN: read dropped, UNDERFLOW pulses 1 cycle, ERROR set. A simultaneous WR_EN is still accepted (COUNT -> 1).
- While EMPTY=1, DATA_OUT holds its last value and must not be relied upon.
- CLR=1 at an edge: pointers and COUNT reset to 0, EMPTY = 1, ERROR = 0. WR_EN/RD_EN in that cycle are ignored, and no OVERFLOW/UNDERFLOW pulse is generated.
- Reset asserted mid-operation: all state is lost immediately, without waiting for PCLK.

Test Plan:
- Reset then idle -> EMPTY=1, ALMOST_EMPTY=1, COUNT=0, FULL=0, ERROR=0.
- Write 0xA5A50001..0xA5A50010 (16 words, DEPTH=16), then read 16 -> FULL=1 after the 16th write, ALMOST_FULL=1 from COUNT=14, read order identical, EMPTY=1 after the last read, no ERROR.
- Full FIFO plus one WR_EN of 0xDEADBEEF -> OVERFLOW pulse of 1 cycle, ERROR=1 sticky, COUNT=16, 0xDEADBEEF never appears on DATA_OUT.
- Full FIFO with WR_EN+RD_EN of 0x12345678 -> COUNT stays 16, head advances, 0x12345678 read last, no OVERFLOW. Empty FIFO with RD_EN+WR_EN of 0x0000CAFE -> UNDERFLOW pulse, COUNT=1, DATA_OUT=0x0000CAFE next cycle.
- Write 20 / read 18 interleaved across the pointer wrap -> data order preserved, COUNT=2, ALMOST_EMPTY=1.
- CLR with COUNT=5 and ERROR=1 -> COUNT=0, EMPTY=1, ERROR=0 next cycle. PRESETn pulsed low between edges with COUNT=7 -> flags reset immediately, asynchronously.
